// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: runs one shared full-adder cell over WIDTH
// cycles, LSB first, to produce a WIDTH-bit sum plus carry-out.
//
// Handshakes: a transfer happens on a rising edge where valid & ready are
// both high. in_ready is high only in IDLE and out_valid only in DONE. Both
// decode from the state register alone, so in_ready never depends on
// in_valid and out_valid never depends on out_ready. A result, once
// presented, stays stable until it is accepted.

// One-bit full adder cell shared by the serial datapath.
module fulladd (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  // Sum and carry of three one-bit inputs.
  always_comb begin
    s  = a ^ b ^ ci;
    co = (a & b) | (a & ci) | (b & ci);
  end

endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic             carry_q;
  logic             cout_q;
  logic [CW-1:0]    cnt;
  logic             fa_s;
  logic             fa_c;

  // The shared cell always sees the current LSBs and the running carry.
  fulladd u_fulladd (
    .a  (sa[0]),
    .b  (sb[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_c)
  );

  // Status and handshake outputs decoded purely from state.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
    sum       = res;
    cout      = cout_q;
  end

  // Sequencer and serial datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sa      <= '0;
      sb      <= '0;
      res     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sa      <= a;
            sb      <= b;
            carry_q <= cin;
            res     <= '0;
            cnt     <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          sa      <= sa >> 1;
          sb      <= sb >> 1;
          // New sum bit enters at the MSB; after WIDTH shifts the LSB of
          // the sum has arrived at bit 0. Written without a part-select so
          // WIDTH=1 elaborates cleanly.
          res     <= (res >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
          carry_q <= fa_c;
          cnt     <= cnt + CW'(1);
          if (cnt == LAST) begin
            cout_q <= fa_c;
            state  <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed cases, backpressure,
// ignored input, mid-operation reset, WIDTH=1 corner and random vectors
// checked against an arithmetic reference (a + b + cin).
module tb_serial_add_ctrl;

  localparam int W = 8;
  localparam int TMO = 100;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=8 instance signals
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  // WIDTH=1 instance signals
  logic       in_valid1 = 1'b0;
  logic       in_ready1;
  logic [0:0] a1 = '0;
  logic [0:0] b1 = '0;
  logic       cin1 = 1'b0;
  logic       out_valid1;
  logic       out_ready1 = 1'b0;
  logic [0:0] sum1;
  logic       cout1;
  logic       busy1;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .a         (a1),
    .b         (b1),
    .cin       (cin1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .sum       (sum1),
    .cout      (cout1),
    .busy      (busy1)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [W:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Step one clock, landing 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver ----------------
  // Runs one operation on the WIDTH=8 instance. hold = cycles out_ready
  // stays low once out_valid is up; noise = drive junk operands with
  // in_valid high while the operation is in flight.
  task automatic do_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                       input logic vc, input int hold, input bit noise,
                       input bit detail);
    int n;
    int lat;
    logic [W:0] exp;
    logic [W-1:0] s0;
    logic c0;

    n = 0;
    while (!in_ready && n < TMO) begin
      tick();
      n++;
    end
    if (n >= TMO) check("in_ready_timeout", 0, 1);

    // reference model: plain (W+1)-bit addition
    exp_q.push_back({1'b0, va} + {1'b0, vb} + {{W{1'b0}}, vc});

    a = va;
    b = vb;
    cin = vc;
    in_valid = 1'b1;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    if (noise) begin
      in_valid = 1'b1;
      a = 8'h11;
      b = 8'h22;
      cin = 1'b1;
    end

    lat = 0;
    while (!out_valid && lat < TMO) begin
      if (detail) begin
        check("busy_in_run", busy, 1);
        check("in_ready_in_run", in_ready, 0);
      end
      tick();
      lat++;
    end
    in_valid = 1'b0;
    if (lat >= TMO) begin
      check("out_valid_timeout", 0, 1);
      void'(exp_q.pop_front());
      return;
    end
    if (detail) check("latency", lat, W);

    exp = exp_q.pop_front();
    check("sum", sum, exp[W-1:0]);
    check("cout", cout, exp[W]);
    s0 = sum;
    c0 = cout;

    for (int i = 0; i < hold; i++) begin
      tick();
      check("bp_out_valid", out_valid, 1);
      check("bp_sum", sum, s0);
      check("bp_cout", cout, c0);
      check("bp_in_ready", in_ready, 0);
    end

    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    if (detail) begin
      check("post_out_valid", out_valid, 0);
      check("post_in_ready", in_ready, 1);
      check("post_busy", busy, 0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // basic add
    do_op(8'h5A, 8'h3C, 1'b0, 0, 1'b0, 1'b1);
    // carry ripple
    do_op(8'hFF, 8'h01, 1'b0, 0, 1'b0, 1'b1);
    do_op(8'hFF, 8'hFF, 1'b1, 0, 1'b0, 1'b1);
    // backpressure
    do_op(8'hA5, 8'h5A, 1'b1, 5, 1'b0, 1'b1);
    // ignored input during RUN
    do_op(8'h40, 8'h02, 1'b0, 2, 1'b1, 1'b1);

    // reset in RUN cycle 4
    a = 8'h5A;
    b = 8'h3C;
    cin = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #2;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_sum", sum, 0);
    check("mid_rst_cout", cout, 0);
    check("mid_rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    do_op(8'h01, 8'h01, 1'b0, 0, 1'b0, 1'b1);

    // WIDTH=1 corner: 1 + 1 + 1 = 3 -> sum=1, cout=1, one-cycle latency
    a1 = 1'b1;
    b1 = 1'b1;
    cin1 = 1'b1;
    in_valid1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    check("w1_busy", busy1, 1);
    check("w1_out_valid_early", out_valid1, 0);
    tick();
    check("w1_out_valid", out_valid1, 1);
    check("w1_sum", sum1, 1);
    check("w1_cout", cout1, 1);
    out_ready1 = 1'b1;
    tick();
    out_ready1 = 1'b0;
    check("w1_in_ready", in_ready1, 1);

    // random vectors
    for (int i = 0; i < 200; i++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
            $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0);
    end

    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial adder controller that sequences a single one-bit full-adder cell (`fulladd`) over WIDTH cycles to produce a WIDTH-bit sum with carry-in and carry-out. It accepts one operand pair through a valid/ready input handshake and shifts the operands through the cell LSB-first while holding the running carry in a flip-flop. It returns the result through a valid/ready output handshake. It sits between a requesting datapath and the shared full-adder cell, trading latency for area.

## Interface
- WIDTH, 8: operand and sum width in bits; legal range 1..32.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair and cin are valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in.
- out_valid  out  1  sum and cout are valid.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result (a + b + cin) mod 2^WIDTH.
- cout  out  1  carry out of bit WIDTH-1.
- busy  out  1  high in RUN or DONE.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- in_ready = (state == IDLE), decoded combinationally from state. busy = (state != IDLE). out_valid = (state == DONE).
- **IDLE**
  - On in_valid & in_ready: load a and b into shift registers sa and sb, set carry_q = cin, clear the result register, set cnt = 0, and go to RUN.
  - With in_valid low: stay in IDLE.
- **RUN, every cycle**
  - The `fulladd` instance takes (sa[0], sb[0], carry_q) and returns (s, c).
  - sa and sb shift right by one. The result register shifts right with s entering at bit WIDTH-1. carry_q <= c. cnt <= cnt + 1.
  - When cnt == WIDTH-1, this is the last bit: go to DONE, and the final carry becomes cout.
- **DONE**
  - sum and cout are held stable.
  - On out_valid & out_ready: go to IDLE.
  - Otherwise stay in DONE indefinitely. Backpressure loses nothing.
- **Ignored inputs**
  - in_valid, a, b and cin are ignored in RUN and DONE. No operand is captured while in_ready is low.
  - out_ready is ignored outside DONE.
- **Arithmetic and widths**
  - Unsigned. sum and cout together equal the (WIDTH+1)-bit value a + b + cin.
  - cnt is ceil(log2(WIDTH)) bits wide, with a minimum of 1 bit.
- **WIDTH = 1:** exactly one RUN cycle, then DONE.
- **Outputs after result acceptance:** sum and cout keep their last values in IDLE. They are only meaningful while out_valid is high.
- **Reset, including mid-operation**
  - Asserting rst_n immediately forces state = IDLE, sa = sb = 0, result = 0, carry_q = 0, cnt = 0.
  - Reset outputs: out_valid = 0, busy = 0, sum = 0, cout = 0, in_ready = 1.
  - Any operation in flight is discarded, and no partial result is ever presented.

## Timing
- Operands are accepted at rising edge E0, where in_valid & in_ready are both high.
- RUN occupies the WIDTH cycles after E0. out_valid rises after edge E0+WIDTH, i.e. WIDTH cycles of latency.
- A result transfers at the edge where out_valid & out_ready are both high. in_ready rises in the following cycle.
- There is no overlap between result acceptance and the next operand capture. Minimum spacing between accepted operations is WIDTH+2 cycles.
- All state is registered; no combinational path from in_valid to in_ready.
- out_valid depends only on state; it has no combinational dependence on out_ready.

## Test plan
- **Basic add:** WIDTH=8, a=0x5A, b=0x3C, cin=0, out_ready=1 → sum=0x96, cout=0. out_valid rises exactly 8 cycles after acceptance; busy is high from acceptance until the output handshake.
- **Carry ripple:** a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1.
- **Backpressure:** hold out_ready=0 for 5 cycles after out_valid rises → out_valid, sum and cout stay stable and in_ready stays 0. Raise out_ready → one transfer, then in_ready=1 on the next cycle.
- **Ignored input:** drive in_valid=1 with a=0x11, b=0x22 during RUN → these operands are not captured, and the in-flight result is unaffected.
- **Reset mid-operation:** pulse rst_n low during RUN cycle 4 → out_valid=0, busy=0, sum=0, cout=0, in_ready=1. A subsequent 0x01+0x01 returns 0x02 with no corruption.
- **Width corner:** WIDTH=1, a=1, b=1, cin=1 → sum=1, cout=1, with out_valid rising 1 cycle after acceptance. Also run 200 random vectors at WIDTH=8 and check against a + b + cin.
